// File: rtl/excess_3_to_bcd_serial.sv
// ---------------------------------------------------------------------------
// excess_3_to_bcd_serial
//
// Bit-serial excess-3 to BCD decoder. Collects DIGITS excess-3 digits
// (least-significant digit first, each digit LSB first), removes the +3 bias
// from each one and presents the whole frame as packed BCD. Any code outside
// 0011..1100 is replaced by 4'hF in its slot and flags the frame as bad.
//
// Parameters
//   DIGITS     digits per frame, 1..8
//
// Ports
//   clock      system clock, rising edge active
//   reset      asynchronous active-high reset, clears all state and outputs
//   clear      synchronous abort of a partial frame (bcd_out/err keep value)
//   bit_valid  bit_in is accepted on a rising edge when high (and clear low)
//   bit_in     serial excess-3 data
//   bcd_out    packed BCD of the last completed frame, digit 0 in [3:0]
//   done       one-cycle pulse after the edge accepting a frame's final bit
//   err        last completed frame contained at least one invalid code
//   busy       a frame is partially received
// ---------------------------------------------------------------------------
module excess_3_to_bcd_serial #(
  parameter int DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  bit_valid,
  input  logic                  bit_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  done,
  output logic                  err,
  output logic                  busy
);

  localparam int          W        = 4 * DIGITS;
  localparam logic [2:0]  LAST_DIG = 3'(DIGITS - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t          state;
  logic [1:0]      bit_cnt;
  logic [2:0]      dig_cnt;
  logic [2:0]      code_sr;     // first three bits of the digit in flight
  logic [W-1:0]    acc;
  logic            frame_err;

  logic [3:0]      code_full;
  logic [3:0]      dig_val;
  logic            dig_bad;
  logic [W-1:0]    acc_nxt;
  logic            err_nxt;
  logic            last_bit;

  // Strip the excess-3 bias; returns {invalid, digit}.
  function automatic logic [4:0] decode_x3(input logic [3:0] c);
    logic [4:0] r;
    if (c >= 4'd3 && c <= 4'd12) r = {1'b0, c - 4'd3};
    else                         r = {1'b1, 4'hF};
    return r;
  endfunction

  // Digit assembly: the incoming bit is the MSB of the code when bit_cnt==3.
  always_comb begin
    code_full          = {bit_in, code_sr};
    {dig_bad, dig_val} = decode_x3(code_full);
    acc_nxt            = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_cnt == 3'(i)) acc_nxt[4*i +: 4] = dig_val;
    end
    err_nxt  = frame_err | dig_bad;
    last_bit = (bit_cnt == 2'd3) && (dig_cnt == LAST_DIG);
  end

  // Control FSM, counters, accumulator and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= 2'd0;
      dig_cnt   <= 3'd0;
      code_sr   <= 3'd0;
      acc       <= '0;
      frame_err <= 1'b0;
      bcd_out   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        // Abort wins over a simultaneous bit; completed results are kept.
        state     <= IDLE;
        busy      <= 1'b0;
        bit_cnt   <= 2'd0;
        dig_cnt   <= 3'd0;
        code_sr   <= 3'd0;
        acc       <= '0;
        frame_err <= 1'b0;
      end else if (bit_valid) begin
        code_sr <= code_full[3:1];
        bit_cnt <= bit_cnt + 2'd1;
        if (last_bit) begin
          state     <= IDLE;
          busy      <= 1'b0;
          dig_cnt   <= 3'd0;
          bcd_out   <= acc_nxt;
          err       <= err_nxt;
          done      <= 1'b1;
          acc       <= '0;
          frame_err <= 1'b0;
        end else begin
          state <= RECV;
          busy  <= 1'b1;
          if (bit_cnt == 2'd3) begin
            acc       <= acc_nxt;
            frame_err <= err_nxt;
            dig_cnt   <= dig_cnt + 3'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_excess_3_to_bcd_serial.sv
// ---------------------------------------------------------------------------
// tb_excess_3_to_bcd_serial
//
// Self-checking bench for excess_3_to_bcd_serial with DIGITS = 4. A table of
// whole frames (packed excess-3 codes, gap length, expected BCD and error
// flag) is applied in a loop; abort, clear-on-final-bit, back-to-back and
// mid-frame reset cases are written out by hand.
// ---------------------------------------------------------------------------
module tb_excess_3_to_bcd_serial;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_in = 1'b0;
  logic [15:0] bcd_out;
  logic        done;
  logic        err;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  excess_3_to_bcd_serial #(.DIGITS(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .bcd_out   (bcd_out),
    .done      (done),
    .err       (err),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] codes;    // digit 0 code in [3:0]
    int          gap;      // idle cycles inserted before each bit after the first
    logic [15:0] exp_bcd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after rising edge.
  task automatic cyc(input logic v, input logic b, input logic c);
    @(negedge clock);
    bit_valid = v;
    bit_in    = b;
    clear     = c;
    @(posedge clock);
    #1;
  endtask

  // Send the first n bits of a frame; counts done pulses and busy drops seen
  // before the final bit of the frame.
  task automatic send_bits(input logic [15:0] codes, input int n, input int gap,
                           output int early_done, output int busy_low);
    early_done = 0;
    busy_low   = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          cyc(1'b0, 1'b0, 1'b0);
          if (done) early_done++;
          if (!busy) busy_low++;
        end
      end
      cyc(1'b1, codes[i], 1'b0);
      if (i < 15) begin
        if (done) early_done++;
        if (!busy) busy_low++;
      end
    end
  endtask

  task automatic check_frame(input string name, input logic [15:0] codes, input int gap,
                             input logic [15:0] exp_bcd, input logic exp_err);
    int ed, bl;
    send_bits(codes, 16, gap, ed, bl);
    chk({name, " done_pulse"}, 16'(done), 16'd1);
    chk({name, " bcd_out"},    bcd_out,   exp_bcd);
    chk({name, " err"},        16'(err),  16'(exp_err));
    chk({name, " busy_after"}, 16'(busy), 16'd0);
    chk({name, " early_done"}, 16'(ed),   16'd0);
    chk({name, " busy_in_frame"}, 16'(bl), 16'd0);
  endtask

  initial begin
    int ed, bl;

    vecs[0] = '{codes: 16'h4567, gap: 0, exp_bcd: 16'h1234, exp_err: 1'b0};
    vecs[1] = '{codes: 16'h4D67, gap: 0, exp_bcd: 16'h1F34, exp_err: 1'b1};
    vecs[2] = '{codes: 16'h3333, gap: 0, exp_bcd: 16'h0000, exp_err: 1'b0};
    vecs[3] = '{codes: 16'hCCCC, gap: 2, exp_bcd: 16'h9999, exp_err: 1'b0};
    vecs[4] = '{codes: 16'h3C3C, gap: 1, exp_bcd: 16'h0909, exp_err: 1'b0};
    vecs[5] = '{codes: 16'h3330, gap: 0, exp_bcd: 16'h000F, exp_err: 1'b1};
    vecs[6] = '{codes: 16'hF12E, gap: 3, exp_bcd: 16'hFFFF, exp_err: 1'b1};

    // Reset held for two cycles
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("reset bcd_out", bcd_out,    16'h0000);
    chk("reset done",    16'(done),  16'd0);
    chk("reset err",     16'(err),   16'd0);
    chk("reset busy",    16'(busy),  16'd0);

    foreach (vecs[k]) begin
      check_frame($sformatf("vec%0d", k), vecs[k].codes, vecs[k].gap,
                  vecs[k].exp_bcd, vecs[k].exp_err);
      cyc(1'b0, 1'b0, 1'b0);
      chk($sformatf("vec%0d done_one_cycle", k), 16'(done), 16'd0);
      chk($sformatf("vec%0d bcd_hold", k), bcd_out, vecs[k].exp_bcd);
    end

    // Abort after 7 bits with clear and bit_valid together, then 5678
    send_bits(16'h4567, 7, 0, ed, bl);
    chk("abort busy_before", 16'(busy), 16'd1);
    cyc(1'b1, 1'b1, 1'b1);
    chk("abort busy",      16'(busy), 16'd0);
    chk("abort done",      16'(done), 16'd0);
    chk("abort bcd_keep",  bcd_out,   16'hFFFF);
    chk("abort err_keep",  16'(err),  16'd1);
    cyc(1'b0, 1'b0, 1'b0);
    check_frame("post_abort_5678", 16'h89AB, 0, 16'h5678, 1'b0);

    // Clear on the same edge as the final bit: no completion
    send_bits(16'h7654, 15, 0, ed, bl);
    cyc(1'b1, 1'b0, 1'b1);
    chk("clear_final done", 16'(done), 16'd0);
    chk("clear_final bcd",  bcd_out,   16'h5678);
    chk("clear_final busy", 16'(busy), 16'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("clear_final no_late_done", 16'(done), 16'd0);

    // Back-to-back frames 0001 then 9000, no idle cycle between them
    check_frame("b2b_0001", 16'h3334, 0, 16'h0001, 1'b0);
    check_frame("b2b_9000", 16'hC333, 0, 16'h9000, 1'b0);

    // Reset mid-frame, checked before the next rising edge
    send_bits(16'h4567, 10, 0, ed, bl);
    @(negedge clock);
    bit_valid = 1'b0;
    reset     = 1'b1;
    #2;
    chk("async_reset bcd_out", bcd_out,   16'h0000);
    chk("async_reset busy",    16'(busy), 16'd0);
    chk("async_reset err",     16'(err),  16'd0);
    chk("async_reset done",    16'(done), 16'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_frame("after_reset_4321", 16'h7654, 0, 16'h4321, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
